ws2812_rx: RTL and testbench



---
 rtl/ws2812_rx.sv | 208 ++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: classifies high-pulse widths into bits, assembles GRB words
// and flags the latch gap. Optional majority glitch filter: WS2812_RX_GLITCH_FILTER_EN.
module ws2812_rx #(
  parameter int unsigned SysClkFreq  = 40_000_000,
  parameter int unsigned BitThreshNs = 600,
  parameter int unsigned MaxHighNs   = 2000,
  parameter int unsigned LatchNs     = 50_000
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_i,
  input  logic        din_i,
  input  logic        en_i,
  output logic [23:0] pixel_o,
  output logic        pixel_valid_o,
  input  logic        pixel_ready_i,
  output logic        frame_end_o,
  output logic [15:0] pixel_count_o,
  output logic        err_timing_o,
  output logic        err_overflow_o,
  input  logic        err_clr_i
);

  localparam int unsigned ClkMhz        = SysClkFreq / 1_000_000;
  localparam int unsigned ThreshCycles  = ClkMhz * BitThreshNs / 1000;
  localparam int unsigned MaxHighCycles = ClkMhz * MaxHighNs / 1000;
  localparam int unsigned LatchCycles   = ClkMhz * LatchNs / 1000;
  localparam int unsigned LoW           = $clog2(LatchCycles + 1);
  localparam int unsigned HiW           = $clog2(MaxHighCycles + 1);

  localparam logic [LoW-1:0] LatchMax  = LoW'(LatchCycles);
  localparam logic [LoW-1:0] LatchPre  = LoW'(LatchCycles - 1);
  localparam logic [HiW-1:0] HiMax     = HiW'(MaxHighCycles);
  // hi_cnt_q lags the pulse length: it reads len-1 on the fall and len-2 on later high samples
  localparam logic [HiW-1:0] ThreshM1  = HiW'(ThreshCycles - 1);
  localparam logic [HiW-1:0] MaxHighM2 = HiW'(MaxHighCycles - 2);

  typedef enum logic [1:0] {StSync, StIdle, StHigh} state_e;

  logic sync1_q, sync2_q, prev_q, sample;

`ifdef WS2812_RX_GLITCH_FILTER_EN
  logic hist1_q, hist2_q;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end

  assign sample = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`else
  assign sample = sync2_q;
`endif

  logic rise, fall;
  assign rise = sample & ~prev_q;
  assign fall = ~sample & prev_q;

  state_e          state_q, state_d;
  logic [LoW-1:0]  lo_cnt_q, lo_cnt_d, lo_inc;
  logic [HiW-1:0]  hi_cnt_q, hi_cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [22:0]     shift_q, shift_d;
  logic            seen_q, seen_d;
  logic [23:0]     pixel_q, pixel_d;
  logic            valid_q, valid_d;
  logic            fe_q, fe_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            err_t_q, err_t_d, err_o_q, err_o_d;
  logic            set_timing, set_ovf, word_done, bit_val;
  logic [23:0]     word;

  assign lo_inc = (lo_cnt_q == LatchMax) ? lo_cnt_q : lo_cnt_q + 1'b1;
  assign word   = {shift_q, bit_val};

  always_comb begin
    state_d    = state_q;
    lo_cnt_d   = lo_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    seen_d     = seen_q;
    pixel_d    = pixel_q;
    valid_d    = valid_q;
    fe_d       = 1'b0;
    cnt_d      = cnt_q;
    set_timing = 1'b0;
    set_ovf    = 1'b0;
    word_done  = 1'b0;
    bit_val    = (hi_cnt_q >= ThreshM1);

    unique case (state_q)
      StSync: begin
        lo_cnt_d = sample ? '0 : lo_inc;
        if (en_i && !sample && lo_inc == LatchMax) state_d = StIdle;
      end
      StIdle: begin
        if (rise) begin
          state_d  = StHigh;
          hi_cnt_d = '0;
        end else begin
          lo_cnt_d = lo_inc;
          if (lo_cnt_q == LatchPre) begin
            fe_d       = seen_q;
            set_timing = (bit_cnt_q != 5'd0);
            bit_cnt_d  = 5'd0;
            seen_d     = 1'b0;
          end
        end
      end
      StHigh: begin
        hi_cnt_d = (hi_cnt_q == HiMax) ? hi_cnt_q : hi_cnt_q + 1'b1;
        if (fall) begin
          shift_d  = word[22:0];
          seen_d   = 1'b1;
          state_d  = StIdle;
          lo_cnt_d = '0;
          if (bit_cnt_q == 5'd23) begin
            word_done = 1'b1;
            bit_cnt_d = 5'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (hi_cnt_q >= MaxHighM2) begin
          set_timing = 1'b1;
          bit_cnt_d  = 5'd0;
          state_d    = StSync;
          lo_cnt_d   = '0;
        end
      end
      default: state_d = StSync;
    endcase

    if (!en_i) begin
      state_d   = StSync;
      bit_cnt_d = 5'd0;
    end

    if (word_done) begin
      if (!valid_q || pixel_ready_i) begin
        pixel_d = word;
        valid_d = 1'b1;
      end else begin
        set_ovf = 1'b1;
      end
    end else if (valid_q && pixel_ready_i) begin
      valid_d = 1'b0;
    end

    // Count clears the cycle after the frame_end pulse
    if (fe_q) begin
      cnt_d = 16'd0;
    end else if (word_done && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end

    err_t_d = set_timing | (err_t_q & ~err_clr_i);
    err_o_d = set_ovf | (err_o_q & ~err_clr_i);
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      state_q   <= StSync;
      lo_cnt_q  <= '0;
      hi_cnt_q  <= '0;
      bit_cnt_q <= 5'd0;
      shift_q   <= '0;
      seen_q    <= 1'b0;
      pixel_q   <= 24'd0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      cnt_q     <= 16'd0;
      err_t_q   <= 1'b0;
      err_o_q   <= 1'b0;
    end else begin
      sync1_q   <= din_i;
      sync2_q   <= sync1_q;
      prev_q    <= sample;
      state_q   <= state_d;
      lo_cnt_q  <= lo_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      seen_q    <= seen_d;
      pixel_q   <= pixel_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      cnt_q     <= cnt_d;
      err_t_q   <= err_t_d;
      err_o_q   <= err_o_d;
    end
  end

  assign pixel_o        = pixel_q;
  assign pixel_valid_o  = valid_q;
  assign frame_end_o    = fe_q;
  assign pixel_count_o  = cnt_q;
  assign err_timing_o   = err_t_q;
  assign err_overflow_o = err_o_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: table of pixel timings plus hand sequences for latch, overflow,
// partial frame, stuck-high, glitch and mid-pulse reset; pixels checked via a scoreboard.
module tb_ws2812_rx;

`ifdef WS2812_RX_GLITCH_FILTER_EN
  localparam int Lat  = 4;
  localparam bit Filt = 1'b1;
`else
  localparam int Lat  = 3;
  localparam bit Filt = 1'b0;
`endif

  logic        clk, rst, din, en, ready, err_clr;
  logic [23:0] pixel;
  logic        pixel_valid, frame_end, err_timing, err_overflow;
  logic [15:0] pixel_count;

  ws2812_rx dut (
    .clk_sys_i      (clk),
    .rst_sys_i      (rst),
    .din_i          (din),
    .en_i           (en),
    .pixel_o        (pixel),
    .pixel_valid_o  (pixel_valid),
    .pixel_ready_i  (ready),
    .frame_end_o    (frame_end),
    .pixel_count_o  (pixel_count),
    .err_timing_o   (err_timing),
    .err_overflow_o (err_overflow),
    .err_clr_i      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          fe_cnt = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [23:0] word;
    int          hi1, lo1, hi0, lo0;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic level, input int n);
    din = level;
    cyc(n);
  endtask

  task automatic send_word(input logic [23:0] w, input int nbits,
                           input int hi1, input int lo1, input int hi0, input int lo0);
    for (int i = 23; i > 23 - nbits; i--) begin
      drive(1'b1, w[i] ? hi1 : hi0);
      drive(1'b0, w[i] ? lo1 : lo0);
    end
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pixel"}, pixel, 24'd0);
    check({tag, "_valid"}, {23'd0, pixel_valid}, 24'd0);
    check({tag, "_frame_end"}, {23'd0, frame_end}, 24'd0);
    check({tag, "_count"}, {8'd0, pixel_count}, 24'd0);
    check({tag, "_err_timing"}, {23'd0, err_timing}, 24'd0);
    check({tag, "_err_overflow"}, {23'd0, err_overflow}, 24'd0);
  endtask

  // Scoreboard: every transfer must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && frame_end) fe_cnt++;
    if (!rst && pixel_valid && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pixel: actual %0h required none", pixel);
      end else begin
        check("pixel_transfer", pixel, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [23:0] gw, gexp, w;

    vecs[0] = '{24'hA5A5A5, 32, 18, 16, 34};
    vecs[1] = '{24'h000000, 32, 18, 16, 34};
    vecs[2] = '{24'hFFFFFF, 32, 18, 16, 34};
    vecs[3] = '{24'hC33C96, 24, 26, 23, 27};
    vecs[4] = '{24'h5A0FF0, 30, 3, 10, 3};
    vecs[5] = '{24'h800001, 79, 5, 3, 5};

    din = 1'b0; en = 1'b1; ready = 1'b0; err_clr = 1'b0; rst = 1'b1;
    cyc(3);
    check_reset_state("reset");
    rst = 1'b0;
    drive(1'b0, 2100);

    // Single pixel with exact output latency
    w = 24'hFF0080;
    exp_q.push_back(w);
    for (int i = 23; i >= 0; i--) begin
      drive(1'b1, w[i] ? 32 : 16);
      if (i != 0) drive(1'b0, w[i] ? 18 : 34);
    end
    din = 1'b0;
    cyc(Lat - 1);
    check("latency_early", {23'd0, pixel_valid}, 24'd0);
    cyc(1);
    check("latency_valid", {23'd0, pixel_valid}, 24'd1);
    check("single_pixel", pixel, 24'hFF0080);
    check("single_count", {8'd0, pixel_count}, 24'd1);
    drive(1'b0, 2100);
    check("single_frame_end", 24'(fe_cnt), 24'd1);
    check("single_count_clr", {8'd0, pixel_count}, 24'd0);
    check("single_no_err", {23'd0, err_timing}, 24'd0);
    check("single_pending", {23'd0, pixel_valid}, 24'd1);
    pulse_ready();
    check("single_consumed", {23'd0, pixel_valid}, 24'd0);

    // Overflow: second word dropped, first held
    exp_q.push_back(24'h123456);
    send_word(24'h123456, 24, 32, 18, 16, 34);
    send_word(24'hABCDEF, 24, 32, 18, 16, 34);
    cyc(4);
    check("ovf_pixel_held", pixel, 24'h123456);
    check("ovf_flag", {23'd0, err_overflow}, 24'd1);
    check("ovf_count", {8'd0, pixel_count}, 24'd2);
    pulse_ready();
    check("ovf_consumed", {23'd0, pixel_valid}, 24'd0);
    drive(1'b0, 2100);
    check("ovf_frame_end", 24'(fe_cnt), 24'd2);
    pulse_clr();
    check("ovf_cleared", {23'd0, err_overflow}, 24'd0);

    // Table of words and bit timings, consumer always ready
    ready = 1'b1;
    foreach (vecs[k]) begin
      exp_q.push_back(vecs[k].word);
      send_word(vecs[k].word, 24, vecs[k].hi1, vecs[k].lo1, vecs[k].hi0, vecs[k].lo0);
      cyc(4);
      check("table_count", {8'd0, pixel_count}, 24'(k + 1));
    end
    drive(1'b0, 2100);
    check("table_frame_end", 24'(fe_cnt), 24'd3);
    check("table_count_clr", {8'd0, pixel_count}, 24'd0);
    check("table_no_ovf", {23'd0, err_overflow}, 24'd0);
    check("table_no_terr", {23'd0, err_timing}, 24'd0);

    // Partial frame
    ready = 1'b0;
    send_word(24'hF0F0F0, 12, 32, 18, 16, 34);
    drive(1'b0, 2100);
    check("partial_frame_end", 24'(fe_cnt), 24'd4);
    check("partial_err", {23'd0, err_timing}, 24'd1);
    check("partial_no_valid", {23'd0, pixel_valid}, 24'd0);
    pulse_clr();
    check("partial_cleared", {23'd0, err_timing}, 24'd0);

    // Stuck high: resync required before decoding resumes
    ready = 1'b1;
    drive(1'b1, 80);
    drive(1'b0, 5);
    check("stuck_err", {23'd0, err_timing}, 24'd1);
    send_word(24'h00FF00, 24, 32, 18, 16, 34);
    cyc(4);
    check("stuck_ignored", {8'd0, pixel_count}, 24'd0);
    drive(1'b0, 2100);
    check("stuck_no_frame_end", 24'(fe_cnt), 24'd4);
    pulse_clr();
    exp_q.push_back(24'h5AA5C3);
    send_word(24'h5AA5C3, 24, 32, 18, 16, 34);
    cyc(4);
    check("stuck_recover_count", {8'd0, pixel_count}, 24'd1);
    check("stuck_recover_terr", {23'd0, err_timing}, 24'd0);
    drive(1'b0, 2100);
    check("stuck_recover_fe", 24'(fe_cnt), 24'd5);

    // One-cycle glitch inside the low gap after the 8th bit
    gw   = 24'h3C5AE7;
    gexp = Filt ? gw : {gw[23:16], 1'b0, gw[15:1]};
    exp_q.push_back(gexp);
    for (int i = 23; i >= 0; i--) begin
      drive(1'b1, gw[i] ? 32 : 16);
      if (i == 16) begin
        drive(1'b0, 8);
        drive(1'b1, 1);
        drive(1'b0, 8);
      end else begin
        drive(1'b0, gw[i] ? 18 : 34);
      end
    end
    cyc(4);
    drive(1'b0, 2100);
    check("glitch_terr", {23'd0, err_timing}, Filt ? 24'd0 : 24'd1);
    check("glitch_fe", 24'(fe_cnt), 24'd6);

    // Reset while a pulse is stuck high with an error pending
    ready = 1'b0;
    send_word(24'h0F0F0F, 10, 32, 18, 16, 34);
    drive(1'b1, 85);
    check("pre_reset_err", {23'd0, err_timing}, 24'd1);
    rst = 1'b1;
    cyc(1);
    check_reset_state("midreset");
    rst = 1'b0;
    din = 1'b0;
    cyc(2);

    check("scoreboard_empty", 24'(exp_q.size()), 24'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
